// File: rtl/mmio_bus_arbiter.sv
// Two-master arbiter for the basic MMIO bus. It serialises req/ack transactions
// into single-cycle MMIO accesses and returns read data to the granted master.
module mmio_bus_arbiter #(
  parameter int unsigned ADDR_W    = 21,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              b_mmio_cs,
  output logic              b_wr,
  output logic              b_rd,
  output logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_wr_data,
  input  logic [DATA_W-1:0] b_rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e              state_q;
  logic                last_grant_q;
  logic                winner_q;
  logic                cmd_wr_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic [DATA_W-1:0]   cmd_wr_data_q;

  logic                b_cs_q;
  logic                b_wr_q;
  logic                b_rd_q;
  logic [ADDR_W-1:0]   b_addr_q;
  logic [DATA_W-1:0]   b_wr_data_q;
  logic                m0_ack_q;
  logic                m1_ack_q;
  logic [DATA_W-1:0]   m0_rd_data_q;
  logic [DATA_W-1:0]   m1_rd_data_q;

  logic                any_req;
  logic                win_m1_d;
  logic                sel_wr_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wr_data_d;

  assign any_req = m0_req | m1_req;

  // Winner selection; round-robin ties go to the master not granted last.
  always_comb begin
    win_m1_d = 1'b0;
    if (PRIO_MODE != 0) begin
      win_m1_d = ~m0_req;
    end else if (m0_req && m1_req) begin
      win_m1_d = ~last_grant_q;
    end else begin
      win_m1_d = m1_req;
    end
  end

  always_comb begin
    sel_wr_d      = m0_wr;
    sel_addr_d    = m0_addr;
    sel_wr_data_d = m0_wr_data;
    if (win_m1_d) begin
      sel_wr_d      = m1_wr;
      sel_addr_d    = m1_addr;
      sel_wr_data_d = m1_wr_data;
    end
  end

  // Control FSM; bus strobes and acks default low so the bus is quiet outside ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      winner_q      <= 1'b0;
      cmd_wr_q      <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wr_data_q <= '0;
      b_cs_q        <= 1'b0;
      b_wr_q        <= 1'b0;
      b_rd_q        <= 1'b0;
      b_addr_q      <= '0;
      b_wr_data_q   <= '0;
      m0_ack_q      <= 1'b0;
      m1_ack_q      <= 1'b0;
      m0_rd_data_q  <= '0;
      m1_rd_data_q  <= '0;
    end else begin
      b_cs_q      <= 1'b0;
      b_wr_q      <= 1'b0;
      b_rd_q      <= 1'b0;
      b_addr_q    <= '0;
      b_wr_data_q <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            winner_q      <= win_m1_d;
            cmd_wr_q      <= sel_wr_d;
            cmd_addr_q    <= sel_addr_d;
            cmd_wr_data_q <= sel_wr_data_d;
            b_cs_q        <= 1'b1;
            b_wr_q        <= sel_wr_d;
            b_rd_q        <= ~sel_wr_d;
            b_addr_q      <= sel_addr_d;
            b_wr_data_q   <= sel_wr_data_d;
            state_q       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!cmd_wr_q) begin
            if (winner_q) begin
              m1_rd_data_q <= b_rd_data;
            end else begin
              m0_rd_data_q <= b_rd_data;
            end
          end
          m0_ack_q <= ~winner_q;
          m1_ack_q <= winner_q;
          state_q  <= ST_DONE;
        end
        ST_DONE: begin
          last_grant_q <= winner_q;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign b_mmio_cs  = b_cs_q;
  assign b_wr       = b_wr_q;
  assign b_rd       = b_rd_q;
  assign b_addr     = b_addr_q;
  assign b_wr_data  = b_wr_data_q;
  assign m0_ack     = m0_ack_q;
  assign m1_ack     = m1_ack_q;
  assign m0_rd_data = m0_rd_data_q;
  assign m1_rd_data = m1_rd_data_q;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed bench for mmio_bus_arbiter: a round-robin and a fixed-priority
// instance share the master stimulus; each has its own MMIO read-data model.
module tb_mmio_bus_arbiter;

  localparam int unsigned ADDR_W = 21;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              m0_req, m0_wr, m1_req, m1_wr;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wr_data, m1_wr_data;

  logic              rr_m0_ack, rr_m1_ack, rr_cs, rr_wr, rr_rd;
  logic [DATA_W-1:0] rr_m0_rd, rr_m1_rd, rr_wdata, rr_rdata;
  logic [ADDR_W-1:0] rr_addr;
  logic              fp_m0_ack, fp_m1_ack, fp_cs, fp_wr, fp_rd;
  logic [DATA_W-1:0] fp_m0_rd, fp_m1_rd, fp_wdata, fp_rdata;
  logic [ADDR_W-1:0] fp_addr;

  int errors = 0;
  int checks = 0;

  function automatic logic [DATA_W-1:0] rd_model(input logic [ADDR_W-1:0] a);
    if (a == 21'h00010) return 32'h1234_5678;
    return {11'h3C5, a};
  endfunction

  assign rr_rdata = rr_rd ? rd_model(rr_addr) : '0;
  assign fp_rdata = fp_rd ? rd_model(fp_addr) : '0;

  mmio_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_MODE(0)) u_rr (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_ack(rr_m0_ack), .m0_rd_data(rr_m0_rd),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_ack(rr_m1_ack), .m1_rd_data(rr_m1_rd),
    .b_mmio_cs(rr_cs), .b_wr(rr_wr), .b_rd(rr_rd), .b_addr(rr_addr),
    .b_wr_data(rr_wdata), .b_rd_data(rr_rdata)
  );

  mmio_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRIO_MODE(1)) u_fp (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_ack(fp_m0_ack), .m0_rd_data(fp_m0_rd),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_ack(fp_m1_ack), .m1_rd_data(fp_m1_rd),
    .b_mmio_cs(fp_cs), .b_wr(fp_wr), .b_rd(fp_rd), .b_addr(fp_addr),
    .b_wr_data(fp_wdata), .b_rd_data(fp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [DATA_W*3+ADDR_W+4:0] got;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    got = {rr_cs, rr_wr, rr_rd, rr_addr, rr_wdata, rr_m0_ack, rr_m1_ack, rr_m0_rd, rr_m1_rd};
    checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_rr: got %h want 0", got); end
    got = {fp_cs, fp_wr, fp_rd, fp_addr, fp_wdata, fp_m0_ack, fp_m1_ack, fp_m0_rd, fp_m1_rd};
    checks++;
    if (got !== '0) begin errors++; $display("FAIL reset_fp: got %h want 0", got); end
    reset = 1'b0;
  endtask

  task automatic test_write();
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 21'h00004; m0_wr_data = 32'hA5A5_0001;
    @(negedge clk);
    checks++;
    if ({rr_cs, rr_wr, rr_rd, rr_m0_ack} !== 4'b1100) begin
      errors++; $display("FAIL wr_strobes: got %b want 1100", {rr_cs, rr_wr, rr_rd, rr_m0_ack});
    end
    checks++;
    if ({rr_addr, rr_wdata} !== {21'h00004, 32'hA5A5_0001}) begin
      errors++; $display("FAIL wr_bus: got %h/%h want 00004/a5a50001", rr_addr, rr_wdata);
    end
    @(negedge clk);
    m0_req = 1'b0;
    checks++;
    if ({rr_cs, rr_wr, rr_addr, rr_wdata, rr_m0_ack, rr_m1_ack} !== {2'b00, 53'h0, 2'b10}) begin
      errors++; $display("FAIL wr_ack: cs=%b wr=%b addr=%h wd=%h ack0=%b ack1=%b want quiet,ack0=1",
                         rr_cs, rr_wr, rr_addr, rr_wdata, rr_m0_ack, rr_m1_ack);
    end
    checks++;
    if (rr_m0_rd !== 32'h0) begin errors++; $display("FAIL wr_rd_data: got %h want 0", rr_m0_rd); end
    repeat (2) @(negedge clk);
    checks++;
    if ({rr_cs, rr_m0_ack} !== 2'b00) begin
      errors++; $display("FAIL wr_after: cs/ack got %b want 00", {rr_cs, rr_m0_ack});
    end
  endtask

  task automatic test_read();
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 21'h00010; m1_wr_data = 32'h0;
    @(negedge clk);
    checks++;
    if ({rr_cs, rr_wr, rr_rd, rr_addr} !== {3'b101, 21'h00010}) begin
      errors++; $display("FAIL rd_strobes: got %b %b %b %h want 1 0 1 00010", rr_cs, rr_wr, rr_rd, rr_addr);
    end
    @(negedge clk);
    m1_req = 1'b0;
    checks++;
    if ({rr_m1_ack, rr_m0_ack, rr_rd} !== 3'b100) begin
      errors++; $display("FAIL rd_ack: ack1/ack0/rd got %b want 100", {rr_m1_ack, rr_m0_ack, rr_rd});
    end
    checks++;
    if (rr_m1_rd !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h want 12345678", rr_m1_rd); end
    checks++;
    if (rr_m0_rd !== 32'h0) begin errors++; $display("FAIL rd_loser: got %h want 0", rr_m0_rd); end
    repeat (2) @(negedge clk);
    checks++;
    if ({rr_m1_ack, rr_m1_rd} !== {1'b0, 32'h1234_5678}) begin
      errors++; $display("FAIL rd_hold: ack=%b data=%h want 0/12345678", rr_m1_ack, rr_m1_rd);
    end
  endtask

  // Both masters request continuously from reset: round-robin alternates, fixed priority starves m1.
  task automatic test_contention();
    logic [3:0] got, exp;
    reset = 1'b1;
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h00020;
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 21'h00030;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp = {(k % 3 == 1), (k % 6 == 2), (k % 6 == 5), (k % 3 == 2)};
      got = {rr_cs, rr_m0_ack, rr_m1_ack, fp_m0_ack | (fp_m1_ack << 0) & 1'b0};
      got[0] = fp_m0_ack;
      checks++;
      if (got !== exp || fp_m1_ack !== 1'b0) begin
        errors++; $display("FAIL contend_c%0d: cs,rr_ack0,rr_ack1,fp_ack0 got %b want %b fp_ack1=%b",
                           k, got, exp, fp_m1_ack);
      end
      if (k % 3 == 1) begin
        checks++;
        if (rr_addr !== ((k % 6 == 1) ? 21'h00020 : 21'h00030) || fp_addr !== 21'h00020) begin
          errors++; $display("FAIL contend_addr_c%0d: rr=%h fp=%h", k, rr_addr, fp_addr);
        end
      end
    end
    checks++;
    if ({rr_m0_rd, rr_m1_rd} !== {rd_model(21'h00020), rd_model(21'h00030)}) begin
      errors++; $display("FAIL contend_rr_data: got %h %h", rr_m0_rd, rr_m1_rd);
    end
    m0_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({fp_cs, fp_addr} !== {1'b1, 21'h00030}) begin
      errors++; $display("FAIL fp_m1_issue: cs=%b addr=%h want 1/00030", fp_cs, fp_addr);
    end
    @(negedge clk);
    m1_req = 1'b0;
    checks++;
    if ({fp_m1_ack, fp_m0_ack, fp_m1_rd, fp_m0_rd} !==
        {2'b10, rd_model(21'h00030), rd_model(21'h00020)}) begin
      errors++; $display("FAIL fp_m1_ack: acks=%b%b d1=%h d0=%h", fp_m1_ack, fp_m0_ack, fp_m1_rd, fp_m0_rd);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 21'h00010;
    @(negedge clk);
    checks++;
    if ({rr_cs, rr_rd} !== 2'b11) begin errors++; $display("FAIL mid_issue: cs/rd got %b want 11", {rr_cs, rr_rd}); end
    reset = 1'b1;
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 21'h00040; m0_wr_data = 32'hDEAD_0005;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({rr_cs, rr_rd, rr_addr, rr_m1_ack, rr_m1_rd} !== '0) begin
      errors++; $display("FAIL mid_abort: cs=%b rd=%b addr=%h ack1=%b d1=%h want all 0",
                         rr_cs, rr_rd, rr_addr, rr_m1_ack, rr_m1_rd);
    end
    @(negedge clk);
    checks++;
    if ({rr_cs, rr_wr, rr_addr, rr_wdata} !== {2'b11, 21'h00040, 32'hDEAD_0005}) begin
      errors++; $display("FAIL mid_m0_first: cs=%b wr=%b addr=%h wd=%h", rr_cs, rr_wr, rr_addr, rr_wdata);
    end
    @(negedge clk);
    m0_req = 1'b0;
    checks++;
    if ({rr_m0_ack, rr_m1_ack} !== 2'b10) begin
      errors++; $display("FAIL mid_m0_ack: got %b want 10", {rr_m0_ack, rr_m1_ack});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({rr_cs, rr_rd, rr_addr} !== {2'b11, 21'h00010}) begin
      errors++; $display("FAIL mid_m1_issue: cs=%b rd=%b addr=%h", rr_cs, rr_rd, rr_addr);
    end
    @(negedge clk);
    m1_req = 1'b0;
    checks++;
    if ({rr_m1_ack, rr_m1_rd} !== {1'b1, 32'h1234_5678}) begin
      errors++; $display("FAIL mid_m1_ack: ack=%b data=%h want 1/12345678", rr_m1_ack, rr_m1_rd);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drop_req();
    int acks, accesses;
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 21'h00044;
    @(negedge clk);
    m0_req = 1'b0;
    checks++;
    if ({rr_cs, rr_rd, rr_addr} !== {2'b11, 21'h00044}) begin
      errors++; $display("FAIL drop_issue: cs=%b rd=%b addr=%h", rr_cs, rr_rd, rr_addr);
    end
    acks = 0; accesses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      acks += int'(rr_m0_ack) + int'(rr_m1_ack);
      accesses += int'(rr_cs);
    end
    checks++;
    if (acks != 1 || accesses != 0) begin
      errors++; $display("FAIL drop_counts: acks=%0d accesses=%0d want 1/0", acks, accesses);
    end
    checks++;
    if (rr_m0_rd !== rd_model(21'h00044)) begin
      errors++; $display("FAIL drop_data: got %h want %h", rr_m0_rd, rd_model(21'h00044));
    end
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wr_data = '0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wr_data = '0;
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_reset_mid();
    test_drop_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
